// File: rtl/vinsn_scoreboard.sv
// Vector instruction hazard scoreboard and round-robin VFU completion arbiter.
// Optional hazard-stall cycle counter is built when VSB_STALL_CNT_EN is defined.
module vinsn_scoreboard #(
  parameter int unsigned NrSlots = 4,
  parameter int unsigned NrVReg  = 32,
  parameter int unsigned NrVFU   = 4,
  parameter int unsigned IdW     = 4,
  localparam int unsigned RegW   = $clog2(NrVReg),
  localparam int unsigned SlotW  = (NrSlots > 1) ? $clog2(NrSlots) : 1,
  localparam int unsigned VfuW   = (NrVFU > 1) ? $clog2(NrVFU) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [IdW-1:0]             issue_id_i,
  input  logic [RegW-1:0]            issue_vd_i,
  input  logic                       issue_vd_wr_i,
  input  logic [RegW-1:0]            issue_vs1_i,
  input  logic                       issue_vs1_rd_i,
  input  logic [RegW-1:0]            issue_vs2_i,
  input  logic                       issue_vs2_rd_i,
  output logic                       launch_valid_o,
  input  logic                       launch_ready_i,
  input  logic [NrVFU-1:0]           vfu_done_i,
  input  logic [NrVFU-1:0][IdW-1:0]  vfu_done_id_i,
  output logic [NrVFU-1:0]           vfu_done_gnt_o,
  output logic                       done_o,
  output logic [IdW-1:0]             done_insn_id_o,
  output logic [31:0]                stall_cnt_o
);

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [RegW-1:0] vd;
    logic            vd_wr;
    logic [RegW-1:0] vs1;
    logic            vs1_rd;
    logic [RegW-1:0] vs2;
    logic            vs2_rd;
  } slot_t;

  logic [NrSlots-1:0] valid_q, valid_nxt;
  slot_t              slot_q [NrSlots];
  logic [VfuW-1:0]    rr_q, rr_nxt;

  logic               hazard;
  logic               free;
  logic [SlotW-1:0]   free_idx;
  logic               alloc;
  logic               id_clash;

  logic [VfuW-1:0]    winner;
  logic [VfuW-1:0]    cand_idx;
  logic               found;
  logic [NrSlots-1:0] done_match;

  // Hazard check of the incoming insn against every in-flight slot.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hazard   = 1'b0;
    id_clash = 1'b0;
    for (int s = 0; s < NrSlots; s++) begin
      if (valid_q[s]) begin
        if (issue_vs1_rd_i && slot_q[s].vd_wr && (issue_vs1_i == slot_q[s].vd)) hazard = 1'b1;
        if (issue_vs2_rd_i && slot_q[s].vd_wr && (issue_vs2_i == slot_q[s].vd)) hazard = 1'b1;
        if (issue_vd_wr_i && slot_q[s].vd_wr && (issue_vd_i == slot_q[s].vd))   hazard = 1'b1;
        if (issue_vd_wr_i && slot_q[s].vs1_rd && (issue_vd_i == slot_q[s].vs1)) hazard = 1'b1;
        if (issue_vd_wr_i && slot_q[s].vs2_rd && (issue_vd_i == slot_q[s].vs2)) hazard = 1'b1;
        if (issue_id_i == slot_q[s].id) id_clash = 1'b1;
      end
    end
  end

  // Lowest-index invalid slot; descending scan leaves the lowest one last.
  always_comb begin
    free     = 1'b0;
    free_idx = '0;
    for (int s = NrSlots - 1; s >= 0; s--) begin
      if (!valid_q[s]) begin
        free     = 1'b1;
        free_idx = SlotW'(s);
      end
    end
  end

  assign launch_valid_o = issue_valid_i  && !hazard && free && !flush_i;
  assign issue_ready_o  = launch_ready_i && !hazard && free && !flush_i;
  assign alloc          = launch_valid_o && launch_ready_i;

  // Round-robin search starting at rr_q.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < NrVFU; k++) begin
      cand_idx = VfuW'((int'(rr_q) + k) % NrVFU);
      if (!found && vfu_done_i[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  assign done_o         = |vfu_done_i;
  assign vfu_done_gnt_o = done_o ? (NrVFU'(1) << winner) : '0;
  assign done_insn_id_o = done_o ? vfu_done_id_i[winner] : '0;
  assign rr_nxt         = (winner == VfuW'(NrVFU - 1)) ? '0 : winner + VfuW'(1);

  always_comb begin
    for (int s = 0; s < NrSlots; s++) begin
      done_match[s] = valid_q[s] && (slot_q[s].id == done_insn_id_o);
    end
  end

  always_comb begin
    valid_nxt = valid_q;
    if (done_o) valid_nxt = valid_nxt & ~done_match;
    if (alloc)  valid_nxt[free_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_nxt;
      if (done_o) rr_q <= rr_nxt;
    end
  end

  // NOTE: slot payload is not reset; it is only ever read qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      slot_q[free_idx] <= '{id:     issue_id_i,
                            vd:     issue_vd_i,
                            vd_wr:  issue_vd_wr_i,
                            vs1:    issue_vs1_i,
                            vs1_rd: issue_vs1_rd_i,
                            vs2:    issue_vs2_i,
                            vs2_rd: issue_vs2_rd_i};
    end
  end

`ifdef VSB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (issue_valid_i && (hazard || !free) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  unique_issue_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc |-> !id_clash);

  done_id_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |-> (|done_match));

endmodule

// File: tb/tb_vinsn_scoreboard.sv
// Directed bench for vinsn_scoreboard: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_vinsn_scoreboard;
  localparam int NSLOTS = 4;
  localparam int NVFU   = 4;
  localparam int IDW    = 4;
  localparam int REGW   = 5;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      flush_i = 1'b0;
  logic                      issue_valid_i = 1'b0;
  logic                      issue_ready_o;
  logic [IDW-1:0]            issue_id_i = '0;
  logic [REGW-1:0]           issue_vd_i = '0;
  logic                      issue_vd_wr_i = 1'b0;
  logic [REGW-1:0]           issue_vs1_i = '0;
  logic                      issue_vs1_rd_i = 1'b0;
  logic [REGW-1:0]           issue_vs2_i = '0;
  logic                      issue_vs2_rd_i = 1'b0;
  logic                      launch_valid_o;
  logic                      launch_ready_i = 1'b1;
  logic [NVFU-1:0]           vfu_done_i = '0;
  logic [NVFU-1:0][IDW-1:0]  vfu_done_id_i = '0;
  logic [NVFU-1:0]           vfu_done_gnt_o;
  logic                      done_o;
  logic [IDW-1:0]            done_insn_id_o;
  logic [31:0]               stall_cnt_o;

  vinsn_scoreboard #(.NrSlots(NSLOTS), .NrVReg(32), .NrVFU(NVFU), .IdW(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_vd_i(issue_vd_i), .issue_vd_wr_i(issue_vd_wr_i),
    .issue_vs1_i(issue_vs1_i), .issue_vs1_rd_i(issue_vs1_rd_i),
    .issue_vs2_i(issue_vs2_i), .issue_vs2_rd_i(issue_vs2_rd_i),
    .launch_valid_o(launch_valid_o), .launch_ready_i(launch_ready_i),
    .vfu_done_i(vfu_done_i), .vfu_done_id_i(vfu_done_id_i), .vfu_done_gnt_o(vfu_done_gnt_o),
    .done_o(done_o), .done_insn_id_o(done_insn_id_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-flight set is just a list of insns.
  typedef struct {
    int id;
    int vd;  bit vd_wr;
    int vs1; bit vs1_rd;
    int vs2; bit vs2_rd;
  } insn_t;

  insn_t   inflight[$];
  int      m_rr = 0;
  longint  m_stall = 0;

  always @(negedge clk_i) begin
    bit    haz, full, req, hs;
    int    w, idx;
    insn_t n;
    if (!rst_ni) begin
      inflight.delete();
      m_rr    = 0;
      m_stall = 0;
    end else begin
      haz = 0;
      foreach (inflight[i]) begin
        if (issue_vs1_rd_i && inflight[i].vd_wr && int'(issue_vs1_i) == inflight[i].vd) haz = 1;
        if (issue_vs2_rd_i && inflight[i].vd_wr && int'(issue_vs2_i) == inflight[i].vd) haz = 1;
        if (issue_vd_wr_i && inflight[i].vd_wr && int'(issue_vd_i) == inflight[i].vd) haz = 1;
        if (issue_vd_wr_i && inflight[i].vs1_rd && int'(issue_vd_i) == inflight[i].vs1) haz = 1;
        if (issue_vd_wr_i && inflight[i].vs2_rd && int'(issue_vd_i) == inflight[i].vs2) haz = 1;
      end
      full = (inflight.size() >= NSLOTS);
      req = 0; w = 0;
      for (int k = 0; k < NVFU; k++) begin
        idx = (m_rr + k) % NVFU;
        if (!req && vfu_done_i[idx]) begin req = 1; w = idx; end
      end
      check("m_ready",  32'(issue_ready_o),  32'(launch_ready_i && !haz && !full && !flush_i));
      check("m_launch", 32'(launch_valid_o), 32'(issue_valid_i && !haz && !full && !flush_i));
      check("m_done",   32'(done_o),         32'(req));
      check("m_gnt",    32'(vfu_done_gnt_o), req ? (32'd1 << w) : 32'd0);
      check("m_done_id", 32'(done_insn_id_o), req ? 32'(vfu_done_id_i[w]) : 32'd0);
`ifdef VSB_STALL_CNT_EN
      check("m_stall", stall_cnt_o, 32'(m_stall));
      if (issue_valid_i && (haz || full) && m_stall < 64'hFFFF_FFFF) m_stall++;
`else
      check("m_stall", stall_cnt_o, 32'd0);
`endif
      hs = issue_valid_i && !haz && !full && !flush_i && launch_ready_i;
      if (flush_i) begin
        inflight.delete();
        m_rr = 0;
      end else begin
        if (req) begin
          m_rr = (w + 1) % NVFU;
          for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].id == int'(vfu_done_id_i[w])) begin
              inflight.delete(i);
              break;
            end
          end
        end
        if (hs) begin
          n = '{int'(issue_id_i), int'(issue_vd_i), issue_vd_wr_i, int'(issue_vs1_i),
                issue_vs1_rd_i, int'(issue_vs2_i), issue_vs2_rd_i};
          inflight.push_back(n);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic set_issue(input bit v, input int id, input int vd, input int vs1, input int vs2,
                           input bit wr, input bit r1, input bit r2);
    issue_valid_i  = v;
    issue_id_i     = IDW'(id);
    issue_vd_i     = REGW'(vd);
    issue_vs1_i    = REGW'(vs1);
    issue_vs2_i    = REGW'(vs2);
    issue_vd_wr_i  = wr;
    issue_vs1_rd_i = r1;
    issue_vs2_rd_i = r2;
  endtask

  initial begin
    // Reset state
    smp();
    check("rst_ready", 32'(issue_ready_o), 32'd1);
    check("rst_launch", 32'(launch_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_gnt", 32'(vfu_done_gnt_o), 32'd0);
    check("rst_stall", stall_cnt_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // vadd v3 <- v1, v2
    set_issue(1, 1, 3, 1, 2, 1, 1, 1);
    smp();
    check("t1_ready", 32'(issue_ready_o), 32'd1);
    check("t1_launch", 32'(launch_valid_o), 32'd1);
    cyc();

    // RAW on v3 for 7 cycles
    set_issue(1, 2, 5, 3, 4, 1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      smp();
      check("raw_ready", 32'(issue_ready_o), 32'd0);
      cyc();
    end
    issue_valid_i = 1'b0;
    vfu_done_i = 4'b0001;
    vfu_done_id_i[0] = 4'd1;
    smp();
    check("raw_done", 32'(done_o), 32'd1);
    check("raw_done_gnt", 32'(vfu_done_gnt_o), 32'b0001);
    check("raw_done_id", 32'(done_insn_id_o), 32'd1);
    check("raw_freed_same_cycle", 32'(issue_ready_o), 32'd0);
    cyc();
    vfu_done_i = '0;
    issue_valid_i = 1'b1;
    smp();
    check("raw_cleared", 32'(issue_ready_o), 32'd1);
`ifdef VSB_STALL_CNT_EN
    check("stall_7", stall_cnt_o, 32'd7);
`endif
    cyc();

    // Second independent insn, then flush with an issue pending
    set_issue(1, 3, 10, 11, 12, 1, 1, 1);
    smp();
    check("fl_pre_ready", 32'(issue_ready_o), 32'd1);
    cyc();
    set_issue(1, 4, 13, 14, 15, 1, 1, 1);
    flush_i = 1'b1;
    smp();
    check("fl_ready", 32'(issue_ready_o), 32'd0);
    check("fl_launch", 32'(launch_valid_o), 32'd0);
    cyc();
    flush_i = 1'b0;
    set_issue(1, 4, 7, 5, 6, 1, 1, 1);
    smp();
    check("fl_empty", 32'(issue_ready_o), 32'd1);
`ifdef VSB_STALL_CNT_EN
    check("stall_kept", stall_cnt_o, 32'd7);
`endif
    cyc();

    // In flight: id4 vd7 <- v5, v6
    set_issue(1, 5, 7, 20, 21, 1, 0, 0);
    smp(); check("waw", 32'(issue_ready_o), 32'd0); cyc();
    set_issue(1, 5, 5, 20, 21, 1, 0, 0);
    smp(); check("war_vs1", 32'(issue_ready_o), 32'd0); cyc();
    set_issue(1, 5, 6, 20, 21, 1, 0, 0);
    smp(); check("war_vs2", 32'(issue_ready_o), 32'd0); cyc();
    set_issue(0, 5, 8, 7, 7, 1, 0, 0);
    smp();
    check("nohaz_ready", 32'(issue_ready_o), 32'd1);
    check("nohaz_launch", 32'(launch_valid_o), 32'd0);
    cyc();
    vfu_done_i = 4'b0100;
    vfu_done_id_i[2] = 4'd4;
    smp(); check("vfu2_gnt", 32'(vfu_done_gnt_o), 32'b0100); cyc();
    vfu_done_i = '0;

    // Fill all slots, 5th insn stalls on full
    for (int i = 0; i < 4; i++) begin
      set_issue(1, 6 + i, 16 + i, 0, 0, 1, 0, 0);
      smp(); check("fill_ready", 32'(issue_ready_o), 32'd1); cyc();
    end
    set_issue(1, 10, 24, 25, 26, 1, 1, 1);
    smp(); check("full_ready", 32'(issue_ready_o), 32'd0); cyc();
    smp(); check("full_ready2", 32'(issue_ready_o), 32'd0); cyc();
    vfu_done_i = 4'b0010;
    vfu_done_id_i[1] = 4'd7;
    smp();
    check("full_done_gnt", 32'(vfu_done_gnt_o), 32'b0010);
    check("full_done_id", 32'(done_insn_id_o), 32'd7);
    check("full_same_cycle", 32'(issue_ready_o), 32'd0);
    cyc();
    vfu_done_i = '0;
    smp(); check("full_after", 32'(issue_ready_o), 32'd1); cyc();

    // Flush to rr_ptr=0, then three slots and all-ones done requests
    issue_valid_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(1, 11 + i, 8 + i, 0, 0, 1, 0, 0);
      cyc();
    end
    vfu_done_id_i = {4'd14, 4'd13, 4'd12, 4'd11};
    vfu_done_i = 4'b1111;
    set_issue(1, 15, 30, 0, 0, 1, 0, 0);
    smp();
    check("rr_gnt0", 32'(vfu_done_gnt_o), 32'b0001);
    check("rr_id0", 32'(done_insn_id_o), 32'd11);
    check("rr_alloc_with_free", 32'(launch_valid_o), 32'd1);
    cyc();
    issue_valid_i = 1'b0;
    smp();
    check("rr_gnt1", 32'(vfu_done_gnt_o), 32'b0010);
    check("rr_id1", 32'(done_insn_id_o), 32'd12);
    cyc();
    smp();
    check("rr_gnt2", 32'(vfu_done_gnt_o), 32'b0100);
    check("rr_id2", 32'(done_insn_id_o), 32'd13);
    cyc();
    vfu_done_i = 4'b1001;
    vfu_done_id_i[3] = 4'd15;
    smp();
    check("rr_gnt3", 32'(vfu_done_gnt_o), 32'b1000);
    check("rr_id3", 32'(done_insn_id_o), 32'd15);
    cyc();
    vfu_done_i = '0;
    set_issue(1, 1, 30, 8, 9, 1, 1, 1);
    smp(); check("final_empty", 32'(issue_ready_o), 32'd1); cyc();
    issue_valid_i = 1'b0;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
